// File: rtl/seg_display.sv
// rtl/seg_display.sv - CPU-writable 8-digit multiplexed seven-segment display driver
module seg_display #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [2:0]  address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data_output,
  output logic [7:0]  digit_sel,
  output logic [7:0]  segments
);

  localparam logic [2:0] ADDR_LOW  = 3'b000;
  localparam logic [2:0] ADDR_HIGH = 3'b010;
  localparam logic [2:0] ADDR_CTRL = 3'b100;
  localparam logic [2:0] ADDR_STAT = 3'b110;

  logic [15:0] low_q;
  logic [15:0] high_q;
  logic [15:0] ctrl_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;

  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic [7:0]  en_mask;
  logic [7:0]  dp_mask;

  // Active-high gfedcba pattern for a hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // CPU register writes; STAT and odd/unlisted addresses are dropped.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      low_q  <= 16'd0;
      high_q <= 16'd0;
      ctrl_q <= 16'd0;
    end else if (write_enable) begin
      case (address)
        ADDR_LOW:  low_q  <= write_data;
        ADDR_HIGH: high_q <= write_data;
        ADDR_CTRL: ctrl_q <= write_data;
        default:   ;
      endcase
    end
  end

  // Scan timer: each digit slot lasts SCAN_DIV edges, then the index moves on.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
      idx_q <= 3'd0;
    end else if (cnt_q == SCAN_DIV - 16'd1) begin
      cnt_q <= 16'd0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Combinational readback; zero when not reading so the bus sees no stale data.
  always_comb begin
    read_data_output = 16'd0;
    if (read_enable) begin
      case (address)
        ADDR_LOW:  read_data_output = low_q;
        ADDR_HIGH: read_data_output = high_q;
        ADDR_CTRL: read_data_output = ctrl_q;
        ADDR_STAT: read_data_output = {13'd0, idx_q};
        default:   read_data_output = 16'd0;
      endcase
    end
  end

  // Pick the nibble of the digit currently in its scan slot.
  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      3'd0: nibble = low_q[3:0];
      3'd1: nibble = low_q[7:4];
      3'd2: nibble = low_q[11:8];
      3'd3: nibble = low_q[15:12];
      3'd4: nibble = high_q[3:0];
      3'd5: nibble = high_q[7:4];
      3'd6: nibble = high_q[11:8];
      default: nibble = high_q[15:12];
    endcase
  end

  // Drive anodes and cathodes from registered state only; disabled digits stay dark.
  always_comb begin
    en_mask   = ctrl_q[7:0];
    dp_mask   = ctrl_q[15:8];
    glyph     = seg7(nibble);
    digit_sel = 8'hFF;
    segments  = 8'hFF;
    if (en_mask[idx_q]) begin
      digit_sel = ~(8'b1 << idx_q);
      segments  = ~{dp_mask[idx_q], glyph};
    end
  end

endmodule

// File: doc/seg_display.md
Name: seg_display

Overview:
- CPU-writable driver for the board's 8-digit, common-anode, seven-segment display; the output-side counterpart of the 4x4 keypad scanner.
- The keypad drives row lines and samples columns for the CPU to read. This block takes CPU writes and drives time-multiplexed digit-select and segment lines.
- Sits on the I/O bus beside the keypad controller, at port-space base 0xFFFFFC00, using the same address, read_enable and write_enable decode style.

Parameters:
- SCAN_DIV, 16'd50000, clock cycles each digit stays lit before the scan advances. Legal range 1..65535.

Ports:
- clock  in  1  system clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- write_enable  in  1  CPU write strobe.
- read_enable  in  1  CPU read strobe.
- address  in  3  register select within the block.
- write_data  in  16  CPU write data.
- read_data_output  out  16  CPU read data.
- digit_sel  out  8  digit anodes, active-low; bit i selects digit i.
- segments  out  8  segment cathodes, active-low, ordered {dp,g,f,e,d,c,b,a}.

Behaviour:
- Registers:
  - 3'b000 LOW: nibbles for digits 3..0; [3:0] is digit 0.
  - 3'b010 HIGH: nibbles for digits 7..4.
  - 3'b100 CTRL: [7:0] digit enable mask, [15:8] decimal-point mask.
  - 3'b110 STAT: read-only, {13'd0, scan_index}.
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - LOW, HIGH and CTRL = 0; scan counter = 0; scan_index = 0.
  - digit_sel = 8'hFF, segments = 8'hFF, read_data_output = 0.
- Write:
  - On the falling edge with write_enable=1, the register selected by address loads write_data.
  - Writes to 3'b110 and to odd or unlisted addresses are ignored.
  - The new value is visible on the outputs and on readback immediately after that edge.
- Read:
  - Combinational. With read_enable=1 it returns the selected register; unlisted addresses return 0.
  - With read_enable=0 the output is 16'd0, so no latch is inferred.
  - A read at the same address as a same-cycle write returns the old value until the edge.
- Scan:
  - The counter increments every falling edge.
  - When the counter equals SCAN_DIV-1, it wraps to 0 and scan_index advances 7→0 modulo 8.
  - With SCAN_DIV=1, scan_index advances every cycle.
- Outputs (combinational from registered state only, glitch-free per edge):
  - If CTRL[scan_index]=1: digit_sel = ~(8'b1 << scan_index), and segments = ~{CTRL[8+scan_index], seg7(nibble[scan_index])}.
  - If CTRL[scan_index]=0: digit_sel = 8'hFF and segments = 8'hFF. The scan still advances, so the time per digit is constant.
- seg7 table, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Simultaneous write and scan advance: both take effect on the same edge. The digit shown afterwards uses the new register value.

Test Plan:
- Reset behaviour: SCAN_DIV=4, assert reset mid-scan with scan_index=5 → immediately digit_sel=FF, segments=FF; STAT reads 0 after release. Write CTRL=16'h00FF → digit_sel=FE and segments=C0 (digit 0 shows '0').
- Digit decode: write LOW=16'h3210, HIGH=16'hFEDC, CTRL=16'h00FF, SCAN_DIV=4 → every 4 cycles digit_sel steps FE,FD,FB,...,7F,FE. Segments step C0,F9,A4,B0,C6,A1,86,8E.
- Decimal point and enable mask: CTRL=16'h0505 → digits 0 and 2 light with dp low (segments bit7=0). Digits 1 and 3–7 give digit_sel=FF, segments=FF during their slots.
- Register readback: write LOW=16'hA5C3 → read address 000 returns A5C3; read_enable=0 returns 0000. Write to 110 and 001 → no register changes.
- Scan wrap with SCAN_DIV=1: scan_index reads 7 then 0 on consecutive cycles. A write of LOW on the edge where scan_index becomes 0 shows the new digit-0 value immediately.
